// File: rtl/easy_serial_pkg.sv
// Shared constants and FSM state encoding for the alarm status serial link
// (the transmitter and receiver sides both import this package).
package easy_serial_pkg;

   localparam int ES_MSG_W   = 4;
   localparam int ES_TIMEOUT = 64;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RECV     = 2'd1,
      S_GAP      = 2'd2,
      S_WAIT_LOW = 2'd3
   } es_state_e;

endpackage

// File: rtl/easy_serial_in_if.sv
// Receiver-side bundle of the status link: enable, strobe/data inputs and
// the published frame with its status flags.
interface easy_serial_in_if
   import easy_serial_pkg::*;
   #(parameter int MSG_W = ES_MSG_W);

   logic             EN;
   logic             state_send;
   logic             state_out;
   logic [MSG_W-1:0] msg;
   logic             msg_valid;
   logic             msg_changed;
   logic             frame_err;
   logic             link_lost;

   modport master (
      output EN, state_send, state_out,
      input  msg, msg_valid, msg_changed, frame_err, link_lost
   );

   modport slave (
      input  EN, state_send, state_out,
      output msg, msg_valid, msg_changed, frame_err, link_lost
   );

endinterface

// File: rtl/serial_in_shift.sv
// LSB-first deserializer: shifts one bit per enabled cycle, counts bits and
// flags the cycle that completes a word. The counter returns to 0 when idle.
module serial_in_shift #(
   parameter int MSG_W = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             i_shift,
   input  logic             i_bit,
   output logic [MSG_W-1:0] o_word,
   output logic             o_last
);

   localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

   logic [MSG_W-1:0] r_sr;
   logic [CNT_W-1:0] r_cnt;
   logic [MSG_W-1:0] w_word;

   // o_word already includes the bit being sampled so the top can publish on that edge
   generate
      if (MSG_W == 1) begin : g_one
         assign w_word = i_bit;
      end else begin : g_many
         assign w_word = {i_bit, r_sr[MSG_W-1:1]};
      end
   endgenerate

   assign o_word = w_word;
   assign o_last = (r_cnt == CNT_W'(MSG_W - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_sr  <= w_word;
         r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

endmodule

// File: rtl/easy_serial_in.sv
// Status-link receiver: frames the strobe/data pair, publishes each good word
// with valid/changed pulses, and reports framing errors and loss of link.
module easy_serial_in
   import easy_serial_pkg::*;
#(
   parameter int MSG_W   = ES_MSG_W,
   parameter int TIMEOUT = ES_TIMEOUT
) (
   input  logic         CLK,
   input  logic         RST_N,
   easy_serial_in_if.slave bus
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE     = S_IDLE;
   localparam logic [1:0] ST_RECV     = S_RECV;
   localparam logic [1:0] ST_GAP      = S_GAP;
   localparam logic [1:0] ST_WAIT_LOW = S_WAIT_LOW;

   logic [1:0]       r_state;
   logic [MSG_W-1:0] r_msg;
   logic             r_msg_valid;
   logic             r_msg_changed;
   logic             r_frame_err;
   logic             r_have_msg;
   logic [TO_W-1:0]  r_to_cnt;
   logic             r_link_lost;

   logic             w_shift;
   logic             w_last;
   logic             w_publish;
   logic [MSG_W-1:0] w_word;
   logic [TO_W-1:0]  w_to_nxt;

   assign w_shift   = bus.EN && bus.state_send &&
                      ((r_state == ST_IDLE) || (r_state == ST_RECV));
   assign w_publish = w_shift && w_last;

   serial_in_shift #(.MSG_W(MSG_W)) u_shift (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_shift (w_shift),
      .i_bit   (bus.state_out),
      .o_word  (w_word),
      .o_last  (w_last)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state       <= ST_IDLE;
         r_msg         <= '0;
         r_msg_valid   <= 1'b0;
         r_msg_changed <= 1'b0;
         r_frame_err   <= 1'b0;
         r_have_msg    <= 1'b0;
      end else begin
         r_msg_valid   <= 1'b0;
         r_msg_changed <= 1'b0;
         r_frame_err   <= 1'b0;
         if (!bus.EN) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.state_send) r_state <= w_last ? ST_GAP : ST_RECV;
               end
               ST_RECV: begin
                  if (!bus.state_send) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else if (w_last) begin
                     r_state <= ST_GAP;
                  end
               end
               ST_GAP: begin
                  // a strobe still high after the last bit means an over-long frame
                  if (bus.state_send) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_WAIT_LOW;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_WAIT_LOW: begin
                  if (!bus.state_send) r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
            if (w_publish) begin
               r_msg         <= w_word;
               r_msg_valid   <= 1'b1;
               r_msg_changed <= !r_have_msg || (w_word != r_msg);
               r_have_msg    <= 1'b1;
            end
         end
      end
   end

   assign w_to_nxt = (r_to_cnt == TO_W'(TIMEOUT)) ? r_to_cnt : r_to_cnt + 1'b1;

   // publish wins over a simultaneous expiry; EN low freezes the watchdog
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_to_cnt    <= '0;
         r_link_lost <= 1'b0;
      end else if (w_publish) begin
         r_to_cnt    <= '0;
         r_link_lost <= 1'b0;
      end else if (bus.EN) begin
         r_to_cnt    <= w_to_nxt;
         r_link_lost <= (w_to_nxt == TO_W'(TIMEOUT));
      end
   end

   assign bus.msg         = r_msg;
   assign bus.msg_valid   = r_msg_valid;
   assign bus.msg_changed = r_msg_changed;
   assign bus.frame_err   = r_frame_err;
   assign bus.link_lost   = r_link_lost;

endmodule

// File: doc/easy_serial_in.md
Name: easy_serial_in

Overview:
Receiving end of the two-wire status link (start/frame strobe plus data line) driven by the alarm-side periodic serial transmitter. Deserializes each MSG_W-bit frame, publishes it with a one-cycle valid strobe, and flags value changes, framing errors and loss of link. Sits in the monitoring/display side of the alarm system, feeding the status decoder.

Parameters:
MSG_W, 4, data bits per frame (LSB first)
TIMEOUT, 64, cycles with EN high and no valid frame before link_lost asserts (>=2)
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
CLK  in  1  system clock, all sampling on posedge
RST_N  in  1  asynchronous active-low reset
EN  in  1  receiver enable
state_send  in  1  frame strobe: high during the MSG_W data cycles of a frame
state_out  in  1  serial data, one bit per CLK, LSB first, valid while state_send high
msg  out  MSG_W  last valid frame received (held)
msg_valid  out  1  one-cycle pulse: new valid frame in msg
msg_changed  out  1  one-cycle pulse with msg_valid when the value differs from previous msg (always on the first frame after reset)
frame_err  out  1  one-cycle pulse: malformed frame discarded
link_lost  out  1  level: no valid frame for TIMEOUT enabled cycles

Behaviour:
- Reset (RST_N low, async): state IDLE, bit counter 0, shift reg 0, msg=0, msg_valid=0, msg_changed=0, frame_err=0, link_lost=0, timeout counter 0, have_msg=0.
- All outputs registered. Frame format: state_send high for exactly MSG_W consecutive cycles; bit k sampled on k-th high cycle. Min inter-frame gap: 1 cycle with state_send low.
- FSM (advances only when EN=1):
  IDLE: state_send=1 -> store bit0, cnt=1, go RECV (if MSG_W=1, publish directly, go GAP).
  RECV: state_send=1 -> store bit[cnt]; if cnt==MSG_W-1 publish, go GAP, else cnt++. state_send=0 -> frame_err pulse, discard, go IDLE.
  GAP: state_send=0 -> IDLE. state_send=1 (over-long frame) -> frame_err pulse, go WAIT_LOW; already-published msg is kept.
  WAIT_LOW: state_send=0 -> IDLE; stay otherwise, no further frame_err.
- Publish: at the edge sampling the last bit, msg <= assembled word, msg_valid=1 for exactly one cycle; msg_changed=1 same cycle iff !have_msg or word != old msg; have_msg <= 1.
- Latency: msg/msg_valid visible the cycle after the last bit is sampled.
- state_out is don't-care while state_send low.
- Timeout: counter increments each EN=1 cycle, saturates at TIMEOUT; link_lost=1 when counter==TIMEOUT. Publish clears counter and link_lost on the same edge (publish wins over simultaneous expiry). frame_err does not clear the counter.
- EN=0: FSM forced to IDLE (partial frame aborted silently, no frame_err), counter held, link_lost held, msg held, pulses 0.
- Reset mid-frame: all state cleared immediately; a resumed partial frame after reset is seen as a short frame from IDLE.

Decomposition:
- Package easy_serial_pkg: FSM state enum (IDLE, RECV, GAP, WAIT_LOW), default MSG_W/TIMEOUT constants shared with the transmitter side.
- Sub-module serial_in_shift: MSG_W-bit LSB-first shift register with bit counter and "last bit" flag; the top holds the FSM, compare, publish and timeout.

Test Plan:
- Frame 4'b1010 (bits 0,1,0,1 with send high 4 cycles) after reset -> msg=4'hA, msg_valid and msg_changed one cycle, 1 cycle after last bit.
- Same 4'hA frame repeated after 3-cycle gap -> msg_valid=1, msg_changed=0, msg stays 4'hA.
- state_send drops after 2 bits -> frame_err one cycle, no msg_valid, msg unchanged; following good frame 4'h3 accepted.
- state_send held high 6 cycles with bits 1,1,0,0,x,x -> msg=4'h3 published, then frame_err in GAP, no further activity until send low.
- Idle 64 enabled cycles after reset -> link_lost=1 on the 64th; next valid frame clears it at the same edge as msg_valid; EN=0 for 100 cycles does not advance the counter.
- RST_N pulsed low mid-frame -> all outputs 0 asynchronously; EN dropped mid-frame -> silent abort, no frame_err.
